if_stage: RTL

IF_STAGE -- requirements
Module: if_stage

---
 rtl/if_stage.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, single-outstanding imem handshake, IF/ID register.
// Define IF_MISALIGN_TRAP_EN to trap on misaligned redirect targets.
module if_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall_n,
   input  logic        flush,
   input  logic [31:0] branchTarget,
   output logic        imemReq,
   output logic [31:0] imemAddr,
   input  logic [31:0] imemRdata,
   input  logic        imemValid,
   output logic [31:0] ifidPc,
   output logic [31:0] ifidInstr,
   output logic        ifidValid,
   output logic        fetchBusy,
   output logic        misaligned
);

`ifdef IF_MISALIGN_TRAP_EN
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN, TRAP} state_t;
`else
   typedef enum logic [1:0] {FETCH, HOLD, DRAIN} state_t;
`endif

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] hold_q, hold_d;
   logic [31:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_instr_q, ifid_instr_d;
   logic        ifid_valid_q, ifid_valid_d;
   logic [31:0] target;
   logic [31:0] pc_plus4;
   logic        do_bubble;

`ifdef IF_MISALIGN_TRAP_EN
   logic misaligned_q, misaligned_d;
   assign target     = branchTarget;
   assign misaligned = misaligned_q;
`else
   logic unused_tgt_lsb;
   assign target         = {branchTarget[31:2], 2'b00};
   assign unused_tgt_lsb = ^branchTarget[1:0];
   assign misaligned     = 1'b0;
`endif

   assign pc_plus4  = pc_q + 32'd4;
   assign imemReq   = !rst && (state_q == FETCH);
   assign imemAddr  = pc_q;
   assign fetchBusy = !rst && ((imemReq && !imemValid) ||
                               (state_q == DRAIN));
   assign ifidPc    = ifid_pc_q;
   assign ifidInstr = ifid_instr_q;
   assign ifidValid = ifid_valid_q;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      hold_d       = hold_q;
      ifid_pc_d    = ifid_pc_q;
      ifid_instr_d = ifid_instr_q;
      ifid_valid_d = ifid_valid_q;
      do_bubble    = 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      misaligned_d = misaligned_q;
`endif
      unique case (state_q)
         FETCH: begin
            if (flush) begin
               do_bubble = 1'b1;
               pc_d      = target;
               // request still open: its response must be swallowed
               state_d   = imemValid ? FETCH : DRAIN;
            end else if (imemValid) begin
               if (stall_n) begin
                  ifid_pc_d    = pc_q;
                  ifid_instr_d = imemRdata;
                  ifid_valid_d = 1'b1;
                  pc_d         = pc_plus4;
               end else begin
                  hold_d  = imemRdata;
                  state_d = HOLD;
               end
            end else if (stall_n) begin
               do_bubble = 1'b1;
            end
         end
         HOLD: begin
            if (flush) begin
               do_bubble = 1'b1;
               pc_d      = target;
               state_d   = FETCH;
            end else if (stall_n) begin
               ifid_pc_d    = pc_q;
               ifid_instr_d = hold_q;
               ifid_valid_d = 1'b1;
               pc_d         = pc_plus4;
               state_d      = FETCH;
            end
         end
         DRAIN: begin
            do_bubble = 1'b1;
            if (flush) pc_d = target;
            if (imemValid) state_d = FETCH;
         end
`ifdef IF_MISALIGN_TRAP_EN
         TRAP: begin
            do_bubble = 1'b1;
         end
`endif
         default: begin
            state_d = FETCH;
         end
      endcase
`ifdef IF_MISALIGN_TRAP_EN
      if (flush && (target[1:0] != 2'b00)) begin
         state_d      = TRAP;
         misaligned_d = 1'b1;
         do_bubble    = 1'b1;
      end
`endif
      if (do_bubble) begin
         ifid_instr_d = NOP_INSTR;
         ifid_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FETCH;
         pc_q         <= RESET_PC;
         hold_q       <= NOP_INSTR;
         ifid_pc_q    <= RESET_PC;
         ifid_instr_q <= NOP_INSTR;
         ifid_valid_q <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
         misaligned_q <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         hold_q       <= hold_d;
         ifid_pc_q    <= ifid_pc_d;
         ifid_instr_q <= ifid_instr_d;
         ifid_valid_q <= ifid_valid_d;
`ifdef IF_MISALIGN_TRAP_EN
         misaligned_q <= misaligned_d;
`endif
      end
   end

endmodule
